// File: rtl/msg_packet_decoder_if.sv
// rtl/msg_packet_decoder_if.sv - message-stream in / decoded-payload out bundle for msg_packet_decoder
//
// Purpose: groups the message input and decoded payload output signals of
// msg_packet_decoder so that the producer and the decoder share one handle.
//
// Signals:
//   in_msg         message word (bit MSG_WIDTH-1 = header flag)
//   in_msg_nd      in_msg valid this cycle (no backpressure)
//   out_data       payload bits of the current payload word
//   out_nd         out_data valid, one pulse per payload word
//   out_first      first payload word of a packet
//   out_last       final payload word of a packet
//   out_len        length of the packet being decoded
//   out_pkt_count  packets completed without error (wraps)
//   error          sticky protocol-error flag
//
// Modports:
//   master  message producer / result consumer (drives in_msg*)
//   slave   decoder (drives out_*, error)

interface msg_packet_decoder_if #(
    parameter int MSG_WIDTH = 32,
    parameter int LEN_WIDTH = 8
);
    logic [MSG_WIDTH-1:0] in_msg;
    logic                 in_msg_nd;
    logic [MSG_WIDTH-2:0] out_data;
    logic                 out_nd;
    logic                 out_first;
    logic                 out_last;
    logic [LEN_WIDTH-1:0] out_len;
    logic [15:0]          out_pkt_count;
    logic                 error;

    modport master (
        output in_msg,
        output in_msg_nd,
        input  out_data,
        input  out_nd,
        input  out_first,
        input  out_last,
        input  out_len,
        input  out_pkt_count,
        input  error
    );

    modport slave (
        input  in_msg,
        input  in_msg_nd,
        output out_data,
        output out_nd,
        output out_first,
        output out_last,
        output out_len,
        output out_pkt_count,
        output error
    );
endinterface

// File: rtl/msg_packet_decoder.sv
// rtl/msg_packet_decoder.sv - header/payload message-stream packet decoder
//
// Purpose: splits a message stream into packets. A word with the top bit set
// is a header carrying the packet length in its low LEN_WIDTH bits; a word
// with the top bit clear is a payload word. Payload words of a packet are
// re-emitted one cycle later with first/last markers; protocol violations
// raise a sticky error flag without disturbing later decoding.
//
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    msg_packet_decoder_if.slave (in_msg/in_msg_nd in, out_* / error out)
//
// Parameters:
//   MSG_WIDTH  message word width
//   LEN_WIDTH  header length field width, must be <= MSG_WIDTH-1
//              (must match the parameters of the connected interface)

module msg_packet_decoder #(
    parameter int MSG_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    msg_packet_decoder_if.slave   bus
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PAYLOAD = 1'b1;

    logic [0:0]           r_state;
    logic [LEN_WIDTH-1:0] r_remain;
    logic                 r_first_pending;
    logic [MSG_WIDTH-2:0] r_out_data;
    logic                 r_out_nd;
    logic                 r_out_first;
    logic                 r_out_last;
    logic [LEN_WIDTH-1:0] r_out_len;
    logic [15:0]          r_pkt_count;
    logic                 r_error;

    logic                 w_is_header;
    logic                 w_hdr_valid;
    logic                 w_pay_valid;
    logic [LEN_WIDTH-1:0] w_hdr_len;
    logic                 w_hdr_zero;
    logic                 w_in_payload;
    logic                 w_last_word;
    logic                 w_pkt_done;

    assign w_is_header  = bus.in_msg[MSG_WIDTH-1];
    assign w_hdr_valid  = bus.in_msg_nd &  w_is_header;
    assign w_pay_valid  = bus.in_msg_nd & ~w_is_header;
    assign w_hdr_len    = bus.in_msg[LEN_WIDTH-1:0];
    assign w_hdr_zero   = (w_hdr_len == '0);
    assign w_in_payload = (r_state == ST_PAYLOAD);
    assign w_last_word  = (r_remain == LEN_WIDTH'(1));

    // A packet completes either as an empty header or on its final payload
    // word; the two cannot coincide because a word is one or the other.
    assign w_pkt_done = (w_hdr_valid & w_hdr_zero)
                      | (w_pay_valid & w_in_payload & w_last_word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_remain        <= '0;
            r_first_pending <= 1'b0;
            r_out_data      <= '0;
            r_out_nd        <= 1'b0;
            r_out_first     <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_len       <= '0;
            r_pkt_count     <= '0;
            r_error         <= 1'b0;
        end else begin
            // Output strobes are single-cycle; out_data holds otherwise.
            r_out_nd    <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;

            if (w_pkt_done) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end

            if (w_hdr_valid) begin
                // A header while payload is still owed truncates that packet;
                // the new header is nevertheless taken in this same cycle.
                if (w_in_payload) begin
                    r_error <= 1'b1;
                end
                r_out_len       <= w_hdr_len;
                r_remain        <= w_hdr_len;
                r_first_pending <= ~w_hdr_zero;
                r_state         <= w_hdr_zero ? ST_IDLE : ST_PAYLOAD;
            end else if (w_pay_valid) begin
                if (!w_in_payload) begin
                    // Stray payload with no open packet is dropped.
                    r_error <= 1'b1;
                end else begin
                    r_out_data      <= bus.in_msg[MSG_WIDTH-2:0];
                    r_out_nd        <= 1'b1;
                    r_out_first     <= r_first_pending;
                    r_out_last      <= w_last_word;
                    r_first_pending <= 1'b0;
                    r_remain        <= r_remain - LEN_WIDTH'(1);
                    if (w_last_word) begin
                        r_state <= ST_IDLE;
                    end
                end
            end
        end
    end

    assign bus.out_data      = r_out_data;
    assign bus.out_nd        = r_out_nd;
    assign bus.out_first     = r_out_first;
    assign bus.out_last      = r_out_last;
    assign bus.out_len       = r_out_len;
    assign bus.out_pkt_count = r_pkt_count;
    assign bus.error         = r_error;

endmodule

// File: tb/tb_msg_packet_decoder.sv
// tb/tb_msg_packet_decoder.sv - self-checking bench for msg_packet_decoder

module tb_msg_packet_decoder;

    logic clk;
    logic rst_n;

    msg_packet_decoder_if #(.MSG_WIDTH(32), .LEN_WIDTH(8)) bus ();

    msg_packet_decoder #(.MSG_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Reference model: packet-level view of the stream.
    int          m_rem;
    int          m_seen;
    logic        e_nd, e_first, e_last, e_err;
    logic [30:0] e_data;
    logic [7:0]  e_len;
    logic [15:0] e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_rem = 0; m_seen = 0;
        e_nd = 0; e_first = 0; e_last = 0; e_err = 0;
        e_data = '0; e_len = '0; e_cnt = '0;
    endtask

    task automatic model_step(input logic [31:0] w, input logic nd);
        e_nd = 0; e_first = 0; e_last = 0;
        if (nd) begin
            if (w[31]) begin
                if (m_rem > 0) e_err = 1;
                e_len  = w[7:0];
                m_rem  = int'(w[7:0]);
                m_seen = 0;
                if (m_rem == 0) e_cnt = e_cnt + 16'd1;
            end else if (m_rem == 0) begin
                e_err = 1;
            end else begin
                e_nd    = 1;
                e_data  = w[30:0];
                e_first = (m_seen == 0);
                m_seen  = m_seen + 1;
                m_rem   = m_rem - 1;
                e_last  = (m_rem == 0);
                if (e_last) e_cnt = e_cnt + 16'd1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nd"},    32'(bus.out_nd),        32'(e_nd));
        chk({tag, ".first"}, 32'(bus.out_first),     32'(e_first));
        chk({tag, ".last"},  32'(bus.out_last),      32'(e_last));
        chk({tag, ".data"},  32'(bus.out_data),      32'(e_data));
        chk({tag, ".len"},   32'(bus.out_len),       32'(e_len));
        chk({tag, ".cnt"},   32'(bus.out_pkt_count), 32'(e_cnt));
        chk({tag, ".err"},   32'(bus.error),         32'(e_err));
    endtask

    task automatic send(input logic [31:0] w, input logic nd, input bit do_chk, input string tag);
        @(negedge clk);
        bus.in_msg    = w;
        bus.in_msg_nd = nd;
        @(posedge clk);
        model_step(w, nd);
        #1;
        if (do_chk) check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_msg_nd = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        logic        nd;
        n_pass  = 0;
        n_total = 0;
        rst_n = 1'b1;
        bus.in_msg = '0;
        bus.in_msg_nd = 1'b0;
        model_reset();
        do_reset();

        // Three-word packet.
        send(32'h8000_0003, 1, 1, "s31_h");
        send(32'h0000_0011, 1, 1, "s31_p0");
        send(32'h0000_0022, 1, 1, "s31_p1");
        send(32'h0000_0033, 1, 1, "s31_p2");
        chk("s31_last_data", 32'(bus.out_data), 32'h33);
        chk("s31_cnt", 32'(bus.out_pkt_count), 32'd1);
        send(32'h0, 0, 1, "s31_idle");

        // Single-word packet, then an empty packet.
        do_reset();
        send(32'h8000_0001, 1, 1, "s32_h");
        send(32'h0000_ABCD, 1, 1, "s32_p");
        chk("s32_first_last", {30'd0, bus.out_first, bus.out_last}, 32'd3);
        send(32'h8000_0000, 1, 1, "s32_h0");
        chk("s32_cnt", 32'(bus.out_pkt_count), 32'd2);

        // Stray payload in idle, then a normal packet.
        do_reset();
        send(32'h0000_0005, 1, 1, "s33_stray");
        chk("s33_err", 32'(bus.error), 32'd1);
        send(32'h8000_0001, 1, 1, "s33_h");
        send(32'h0000_0007, 1, 1, "s33_p");
        chk("s33_data", 32'(bus.out_data), 32'h7);

        // Truncated packet followed by a complete one.
        do_reset();
        send(32'h8000_0004, 1, 1, "s34_h4");
        send(32'h0000_0001, 1, 1, "s34_p1");
        send(32'h0000_0002, 1, 1, "s34_p2");
        send(32'h8000_0002, 1, 1, "s34_h2");
        send(32'h0000_000A, 1, 1, "s34_pa");
        send(32'h0000_000B, 1, 1, "s34_pb");
        chk("s34_cnt", 32'(bus.out_pkt_count), 32'd1);
        chk("s34_len", 32'(bus.out_len), 32'd2);

        // Reset in mid-packet, then a stray word.
        do_reset();
        send(32'h8000_0003, 1, 1, "s35_h");
        send(32'h0000_0005, 1, 1, "s35_p");
        do_reset();
        send(32'h0000_0009, 1, 1, "s35_stray");
        chk("s35_err", 32'(bus.error), 32'd1);

        // Randomized stream with gaps and header bits above the length field.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            nd = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0)
                w = {1'b1, 23'($urandom), 8'($urandom_range(0, 4))};
            else
                w = {1'b0, 31'($urandom)};
            send(w, nd, 1, "rand");
        end

        // Packet counter wrap with back-to-back empty headers.
        do_reset();
        for (int i = 0; i < 65535; i++) send(32'h8000_0000, 1, 0, "wrap");
        chk("wrap_ffff", 32'(bus.out_pkt_count), 32'hFFFF);
        send(32'h8000_0000, 1, 1, "wrap_last");
        chk("wrap_zero", 32'(bus.out_pkt_count), 32'h0);
        chk("wrap_err", 32'(bus.error), 32'h0);
        send(32'h0, 0, 1, "wrap_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/msg_packet_decoder.md
MSG_PACKET_DECODER -- requirements
Module: msg_packet_decoder

Interface
REQ-001 Parameter MSG_WIDTH, default 32, width of one message-stream word.
REQ-002 Parameter LEN_WIDTH, default 8, width of the header length field; LEN_WIDTH SHALL be no greater than MSG_WIDTH-1.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_msg  input  MSG_WIDTH  incoming message word.
REQ-006 in_msg_nd  input  1  in_msg is valid this cycle; no backpressure exists.
REQ-007 out_data  output  MSG_WIDTH-1  payload bits of the current payload word.
REQ-008 out_nd  output  1  out_data is valid, single-cycle pulse per word.
REQ-009 out_first  output  1  asserted with out_nd on the first payload word of a packet.
REQ-010 out_last  output  1  asserted with out_nd on the final payload word of a packet.
REQ-011 out_len  output  LEN_WIDTH  length of the packet currently being decoded, held from the header until the next header.
REQ-012 out_pkt_count  output  16  count of packets completed without error.
REQ-013 error  output  1  sticky protocol-error flag.

Function
REQ-014 A word with in_msg[MSG_WIDTH-1]=1 SHALL be decoded as a header, with length L=in_msg[LEN_WIDTH-1:0]; all other header bits SHALL be ignored.
REQ-015 A word with in_msg[MSG_WIDTH-1]=0 SHALL be decoded as a payload word carrying in_msg[MSG_WIDTH-2:0].
REQ-016 Words with in_msg_nd=0 SHALL be ignored entirely.
REQ-017 The state machine SHALL have exactly two states: IDLE (awaiting header) and PAYLOAD (remaining count R>0).
REQ-018 IDLE + header with L>0 -> PAYLOAD, R=L, out_len=L.
REQ-019 IDLE + header with L=0 -> stay IDLE, out_len=0, out_pkt_count+1, no out_nd.
REQ-020 IDLE + payload word -> error set, word dropped, stay IDLE.
REQ-021 PAYLOAD + payload word -> out_data/out_nd registered on the next cycle (latency 1), R-1; on R=1 -> assert out_last, out_pkt_count+1, return to IDLE.
REQ-022 out_first SHALL assert on the first payload word after each header; for L=1, out_first and out_last SHALL assert together.
REQ-023 PAYLOAD + header (truncated packet) -> error set, current packet abandoned without out_last and without a count increment, and the new header processed per REQ-018/019 in the same cycle.
REQ-024 out_nd, out_first and out_last SHALL be zero in every cycle that does not carry a valid payload word; out_data SHALL hold its last value when out_nd=0.
REQ-025 out_pkt_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-026 error SHALL remain set until reset, and SHALL NOT alter decoding of subsequent packets.
REQ-027 Back-to-back valid words on consecutive cycles SHALL be accepted at the full rate of one word per clock.

Reset
REQ-028 While rst_n=0: state=IDLE, R=0, out_data=0, out_nd=0, out_first=0, out_last=0, out_len=0, out_pkt_count=0, error=0.
REQ-029 Reset asserted mid-packet SHALL discard the partial packet with no out_last; the first word after release SHALL be treated as arriving in IDLE.

Verification
REQ-030 The following scenarios use MSG_WIDTH=32 and LEN_WIDTH=8.
REQ-031 Stimulus 0x80000003, 0x00000011, 0x00000022, 0x00000033 on consecutive cycles -> out_nd pulses carrying 0x11, 0x22, 0x33, out_first on 0x11, out_last on 0x33, out_len=3, out_pkt_count=1, error=0.
REQ-032 Stimulus 0x80000001, 0x0000ABCD -> single out_nd with out_first=out_last=1 and out_data=0xABCD; then 0x80000000 -> no out_nd, out_pkt_count=2.
REQ-033 Stimulus 0x00000005 in IDLE -> no out_nd, error=1; then 0x80000001, 0x00000007 -> out_data=0x07 with out_last, error still 1.
REQ-034 Stimulus 0x80000004, 0x1, 0x2, 0x80000002, 0xA, 0xB -> outputs 0x1, 0x2 with no out_last, then 0xA (first) and 0xB (last), error=1, out_pkt_count=1, out_len=2.
REQ-035 Stimulus header 0x80000003 plus one payload word, then reset pulsed, then 0x00000009 -> no out_last before reset, all outputs zero during reset, error=1 after the stray 0x9.
REQ-036 Stimulus of 65536 zero-length headers (0x80000000) -> out_pkt_count wraps to 0x0000, error=0.
